// File: rtl/fas_bist_if.sv
// Operand/result bundle between the BIST engine and the FAS adder/subtractor.
interface fas_bist_if;
    logic [7:0] A;
    logic [7:0] B;
    logic       S;
    logic [7:0] Sum;
    logic       Cout;

    modport master (output A, B, S, input Sum, Cout);
    modport slave  (input A, B, S, output Sum, Cout);
endinterface

// File: rtl/fas_bist.sv
// Self-test engine for the 8-bit FAS: drives a fixed vector sequence, checks
// Sum/Cout against a golden result delayed by LAT cycles, and reports status.
module fas_bist #(
    parameter int         NVEC = 512,
    parameter int         LAT  = 0,
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic        fail_valid,
    output logic [8:0]  fail_idx,
    output logic [1:0]  dbg_state,
    fas_bist_if.master  fas
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [9:0] NV = 10'(NVEC);

    state_t     state;
    logic [9:0] vidx;
    logic [1:0] dcnt;

    // Stage 0 is aligned with the vector currently on A/B/S; stage LAT meets Sum/Cout.
    logic [LAT:0] vld;
    logic [8:0]   exp_res  [0:LAT];
    logic [8:0]   idx_pipe [0:LAT];

    logic       issue;
    logic [8:0] issue_idx;
    logic [7:0] cur_a;
    logic [7:0] cur_b;
    logic       cur_s;
    logic [8:0] cur_res;
    logic       hit;

    assign dbg_state = state;

    always_comb begin
        issue     = 1'b0;
        issue_idx = vidx[8:0];
        if (state == IDLE && start) begin
            issue     = 1'b1;
            issue_idx = 9'd0;
        end else if (state == RUN && vidx < NV) begin
            issue = 1'b1;
        end
        cur_a = issue_idx[7:0];
        cur_b = {issue_idx[3:0], issue_idx[7:4]} ^ SEED;
        cur_s = issue_idx[8];
        if (cur_s)
            cur_res = {1'b0, cur_a} + {1'b0, ~cur_b} + 9'd1;
        else
            cur_res = {1'b0, cur_a} + {1'b0, cur_b};
    end

    assign hit = vld[LAT] && ({fas.Cout, fas.Sum} != exp_res[LAT]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld   <= '0;
            fas.A <= 8'd0;
            fas.B <= 8'd0;
            fas.S <= 1'b0;
        end else begin
            vld[0] <= issue;
            if (issue) begin
                fas.A       <= cur_a;
                fas.B       <= cur_b;
                fas.S       <= cur_s;
                exp_res[0]  <= cur_res;
                idx_pipe[0] <= issue_idx;
            end
            for (int k = 1; k <= LAT; k++) begin
                vld[k]      <= vld[k-1];
                exp_res[k]  <= exp_res[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
        end
    end

    // start is a level request taken only in IDLE (no queuing); busy spans
    // RUN..DONE and done pulses for the single DONE cycle of each run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 16'd0;
            fail_valid <= 1'b0;
            fail_idx   <= 9'd0;
            vidx       <= 10'd0;
            dcnt       <= 2'd0;
        end else begin
            done <= 1'b0;
            if (hit) begin
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_idx   <= idx_pipe[LAT];
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= 16'd0;
                        fail_valid <= 1'b0;
                        fail_idx   <= 9'd0;
                        vidx       <= 10'd1;
                    end
                end
                RUN: begin
                    if (vidx < NV) begin
                        vidx <= vidx + 10'd1;
                    end else if (LAT == 0) begin
                        // Final compare lands on this edge, so fold it into pass.
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_count == 16'd0) && !hit;
                    end else begin
                        state <= DRAIN;
                        dcnt  <= 2'd0;
                    end
                end
                DRAIN: begin
                    if (dcnt == 2'(LAT - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_count == 16'd0) && !hit;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fas_bist.md
# fas_bist

Built-in self-test engine for the 8-bit adder/subtractor `FAS` (ports A, B, S, Sum, Cout). On a start request it drives a deterministic sequence of operand/mode vectors into `FAS`, compares the returned Sum/Cout against an internally computed golden result, and reports the pass/fail status, an error count and the index of the first failing vector. It replaces the hand-written two-vector bench: the block drives the `FAS` inputs and consumes its outputs in hardware, so the same check runs in simulation and on silicon.

## Interface
- NVEC, 512: number of vectors per run; legal range is 1..512.
- LAT, 0: pipeline stages between the A/B/S outputs and the Sum/Cout inputs; legal range is 0..3. It is 0 for the combinational `FAS`.
- SEED, 8'hA5: XOR mask applied to the B operand.

- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high in RUN, DRAIN and DONE.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  1 when the last completed run had zero mismatches.
- err_count  out  16  mismatches in the current or last run; saturates at 16'hFFFF.
- fail_valid  out  1  at least one mismatch has been captured.
- fail_idx  out  9  vector index of the first mismatch.
- A  out  8  operand A to `FAS`.
- B  out  8  operand B to `FAS`.
- S  out  1  mode to `FAS`: 0 = add, 1 = subtract.
- Sum  in  8  result from `FAS`.
- Cout  in  1  carry/no-borrow from `FAS`.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE→RUN when start=1.
  - RUN→DRAIN after vector NVEC-1 is issued. If LAT=0, RUN→DONE directly.
  - DRAIN→DONE after LAT cycles.
  - DONE→IDLE unconditionally.
- Vector i (9-bit index, 0..NVEC-1) is defined as:
  - A = i[7:0]
  - B = {i[3:0], i[7:4]} ^ SEED
  - S = i[8]
- Golden result:
  - S=0: {Cout, Sum} = A + B (9-bit sum).
  - S=1: {Cout, Sum} = A + ~B + 1 (9-bit). Cout=1 means no borrow, i.e. A ≥ B unsigned.
- Expected {Cout, Sum} and the index i travel through a LAT-deep delay line alongside the vector. A compare is valid only for issued vectors; there are no compares during IDLE or DONE.
- A mismatch is any difference in Sum or Cout. On a mismatch:
  - err_count increments, saturating at 16'hFFFF.
  - On the first mismatch of a run, fail_idx captures the index and fail_valid sets. Later mismatches do not change fail_idx.
- On the start edge, err_count, fail_valid, fail_idx and pass clear.
- In DONE, pass = (err_count==0 after the final compare). pass and the counters hold until the next start or reset.
- start during RUN, DRAIN or DONE is ignored; there is no queuing.
- A, B and S are registered. They hold the last issued vector after the run completes and return to 0 only on reset.

## Timing
- Reset (rst_n=0 at an edge) forces the following values next cycle:
  - state = IDLE
  - busy=0, done=0, pass=0
  - err_count=0, fail_valid=0, fail_idx=0
  - A=0, B=0, S=0
  - delay line valid bits = 0
- Reset during a run aborts it immediately: no done pulse, and counters are cleared.
- With start=1 sampled at edge t:
  - Vector i is presented on A/B/S during cycle t+1+i.
  - Its compare happens at the edge ending cycle t+1+i+LAT.
- The final compare and the transition to DONE happen at the same edge, so the DONE cycle sees the final err_count.
- done is high only in cycle t+1+NVEC+LAT, which is cycle t+513 at the defaults.
- busy rises in cycle t+1 and falls after the done cycle.
- A new start is accepted in the first IDLE cycle after DONE; back-to-back runs have a one-cycle gap.

## Test plan
- Golden `FAS`, defaults, start pulse at cycle 5:
  - Cycle 6: A=00, B=A5, S=0.
  - Cycle 6+266: A=0A, B=05, S=1, and the model returns Sum=05, Cout=1.
  - done in cycle 518, pass=1, err_count=0, fail_valid=0.
- Faulty model inverts Sum[0] only when S=1: err_count=256, fail_idx=9'h100, fail_valid=1, pass=0.
- Faulty model inverts Sum[0] always: err_count=512, fail_idx=0, pass=0. A following clean run with the golden model gives pass=1, err_count=0, fail_valid=0.
- LAT=2 with a 2-stage registered `FAS` wrapper: no mismatches, done in cycle t+515. The same bench with LAT=0 against that wrapper gives pass=0.
- start held high through a whole run: exactly one run and one done pulse, then a second run starts in the first IDLE cycle after DONE.
- rst_n=0 in cycle t+100 of a run:
  - Next cycle: busy=0, err_count=0, A=B=S=0.
  - No done pulse.
  - A subsequent start runs normally to pass=1.
